// File: rtl/prog_loader.sv
// prog_loader: program download sequencer between the UART receiver, the CPU
// and the lo/hi byte word memory.
//
// While rx_prog is high, received bytes are paired into little-endian 16-bit
// words and written to memory from LOAD_BASE upward. The CPU is held in reset
// for the whole download and for RELEASE_CYC cycles afterwards. A lone trailing
// byte is written as a byte access when the download ends.
//
// Optional feature: define PROG_LOADER_CSUM_EN to build the 8-bit running byte
// checksum on csum. Without it, csum is tied to zero.
//
// state | meaning
// ------+-------------------------------------------------------------
// REL   | CPU held in reset, counting down to release
// RUN   | CPU runs and owns the memory port (pass-through)
// LO    | download: waiting for the low byte of the next word
// HI    | download: waiting for the high byte of the next word
// FLUSH | download ended on an odd byte: one byte write of that byte

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif

module prog_loader #(
  parameter int                    ADDR_WIDTH  = `ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] LOAD_BASE   = 'h300,
  parameter int                    RELEASE_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_prog,
  input  logic [7:0]            recv_data,
  input  logic                  recv_data_v,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_wr,
  input  logic                  cpu_byt,
  input  logic [15:0]           cpu_wr_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr,
  output logic                  mem_byt,
  output logic [15:0]           mem_wr_data,
  output logic                  cpu_rst,
  output logic                  loading,
  output logic [15:0]           load_cnt,
  output logic                  ovf,
  output logic [7:0]            csum
);

  typedef enum logic [2:0] {
    REL   = 3'd0,
    RUN   = 3'd1,
    LO    = 3'd2,
    HI    = 3'd3,
    FLUSH = 3'd4
  } state_t;

  localparam logic [7:0]          REL_LAST = 8'(RELEASE_CYC - 1);
  localparam logic [ADDR_WIDTH:0] PTR_STEP = (ADDR_WIDTH + 1)'(2);

  state_t                state;
  logic [7:0]            rel_cnt;
  // One extra bit so the pointer can sit just past the top of memory
  // without wrapping back to address zero.
  logic [ADDR_WIDTH:0]   ptr;
  logic [7:0]            lo_buf;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           data_q;
  logic                  byt_q;
  logic                  wr_q;
  logic                  run;
  logic                  word_ovf;
  logic                  byte_ovf;
  logic                  cnt_full;

  // A word fits only if both bytes are inside memory; a byte needs one.
  assign word_ovf = ptr[ADDR_WIDTH] | (&ptr[ADDR_WIDTH-1:0]);
  assign byte_ovf = ptr[ADDR_WIDTH];
  assign cnt_full = (load_cnt == 16'hFFFF);
  assign run      = (state == RUN);

  // Memory port mux: CPU passes straight through in RUN, loader regs otherwise.
  assign mem_addr    = run ? cpu_addr    : addr_q;
  assign mem_wr      = run ? cpu_wr      : wr_q;
  assign mem_byt     = run ? cpu_byt     : byt_q;
  assign mem_wr_data = run ? cpu_wr_data : data_q;

`ifndef PROG_LOADER_CSUM_EN
  assign csum = 8'h00;
`endif

  // Download sequencer, release timer and loader write registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= REL;
      rel_cnt  <= 8'd0;
      ptr      <= {1'b0, LOAD_BASE};
      lo_buf   <= 8'h00;
      addr_q   <= '0;
      data_q   <= 16'h0000;
      byt_q    <= 1'b0;
      wr_q     <= 1'b0;
      cpu_rst  <= 1'b1;
      loading  <= 1'b1;
      load_cnt <= 16'h0000;
      ovf      <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
      csum     <= 8'h00;
`endif
    end else begin
      // Loader writes last exactly one cycle.
      wr_q <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
      // Every accepted byte counts, including ones dropped by overflow.
      if (recv_data_v && (state == LO || state == HI))
        csum <= csum + recv_data;
`endif
      case (state)
        REL: begin
          if (rx_prog) begin
            state   <= LO;
            rel_cnt <= 8'd0;
          end else if (rel_cnt == REL_LAST) begin
            state   <= RUN;
            rel_cnt <= 8'd0;
            cpu_rst <= 1'b0;
            loading <= 1'b0;
          end else begin
            rel_cnt <= rel_cnt + 8'd1;
          end
        end

        RUN: begin
          if (rx_prog) begin
            state    <= LO;
            ptr      <= {1'b0, LOAD_BASE};
            load_cnt <= 16'h0000;
            ovf      <= 1'b0;
            cpu_rst  <= 1'b1;
            loading  <= 1'b1;
`ifdef PROG_LOADER_CSUM_EN
            csum     <= 8'h00;
`endif
          end
        end

        LO: begin
          if (recv_data_v) begin
            lo_buf <= recv_data;
            state  <= HI;
          end else if (!rx_prog) begin
            state   <= REL;
            rel_cnt <= 8'd0;
          end
        end

        HI: begin
          if (recv_data_v) begin
            state <= LO;
            if (word_ovf) begin
              ovf <= 1'b1;
            end else begin
              wr_q   <= 1'b1;
              byt_q  <= 1'b0;
              addr_q <= ptr[ADDR_WIDTH-1:0];
              data_q <= {recv_data, lo_buf};
              ptr    <= ptr + PTR_STEP;
              if (!cnt_full) load_cnt <= load_cnt + 16'd1;
            end
          end else if (!rx_prog) begin
            // Trailing odd byte: the byte write is presented during FLUSH.
            state <= FLUSH;
            if (byte_ovf) begin
              ovf <= 1'b1;
            end else begin
              wr_q   <= 1'b1;
              byt_q  <= 1'b1;
              addr_q <= ptr[ADDR_WIDTH-1:0];
              data_q <= {8'h00, lo_buf};
              ptr    <= ptr + PTR_STEP;
              if (!cnt_full) load_cnt <= load_cnt + 16'd1;
            end
          end
        end

        FLUSH: begin
          state   <= REL;
          rel_cnt <= 8'd0;
        end

        default: begin
          state   <= REL;
          rel_cnt <= 8'd0;
          cpu_rst <= 1'b1;
          loading <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a per-cycle vector table for reset
// release and a first download, then hand-written sequences for the trailing
// byte flush, memory-end overflow and asynchronous reset mid-operation.

module tb_prog_loader;

`ifdef PROG_LOADER_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        rx_prog;
  logic [7:0]  recv_data;
  logic        recv_data_v;
  logic [11:0] cpu_addr;
  logic [10:0] cpu_addr_s;
  logic        cpu_wr;
  logic        cpu_byt;
  logic [15:0] cpu_wr_data;

  logic [11:0] mem_addr;
  logic        mem_wr;
  logic        mem_byt;
  logic [15:0] mem_wr_data;
  logic        cpu_rst;
  logic        loading;
  logic [15:0] load_cnt;
  logic        ovf;
  logic [7:0]  csum;

  logic [10:0] s_mem_addr;
  logic        s_mem_wr;
  logic        s_mem_byt;
  logic [15:0] s_mem_wr_data;
  logic        s_cpu_rst;
  logic        s_loading;
  logic [15:0] s_load_cnt;
  logic        s_ovf;
  logic [7:0]  s_csum;

  int checks = 0;
  int failures = 0;

  assign cpu_addr_s = cpu_addr[10:0];

  prog_loader #(.ADDR_WIDTH(12), .LOAD_BASE(12'h300), .RELEASE_CYC(4)) u_dut (
    .clk(clk), .rst(rst), .rx_prog(rx_prog), .recv_data(recv_data),
    .recv_data_v(recv_data_v), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr),
    .cpu_byt(cpu_byt), .cpu_wr_data(cpu_wr_data), .mem_addr(mem_addr),
    .mem_wr(mem_wr), .mem_byt(mem_byt), .mem_wr_data(mem_wr_data),
    .cpu_rst(cpu_rst), .loading(loading), .load_cnt(load_cnt), .ovf(ovf),
    .csum(csum)
  );

  // Small memory with the load base near the top, for the overflow case.
  prog_loader #(.ADDR_WIDTH(11), .LOAD_BASE(11'h7FC), .RELEASE_CYC(4)) u_small (
    .clk(clk), .rst(rst), .rx_prog(rx_prog), .recv_data(recv_data),
    .recv_data_v(recv_data_v), .cpu_addr(cpu_addr_s), .cpu_wr(cpu_wr),
    .cpu_byt(cpu_byt), .cpu_wr_data(cpu_wr_data), .mem_addr(s_mem_addr),
    .mem_wr(s_mem_wr), .mem_byt(s_mem_byt), .mem_wr_data(s_mem_wr_data),
    .cpu_rst(s_cpu_rst), .loading(s_loading), .load_cnt(s_load_cnt), .ovf(s_ovf),
    .csum(s_csum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rx;
    logic        v;
    logic [7:0]  d;
    logic        cw;
    logic        cb;
    logic [11:0] ca;
    logic [15:0] cd;
    logic        e_rst;
    logic        e_load;
    logic        e_wr;
    logic        chk_bus;
    logic        e_byt;
    logic [11:0] e_addr;
    logic [15:0] e_data;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic rx, logic v, logic [7:0] d, logic cw, logic cb,
                              logic [11:0] ca, logic [15:0] cd, logic e_rst,
                              logic e_load, logic e_wr, logic chk_bus, logic e_byt,
                              logic [11:0] e_addr, logic [15:0] e_data,
                              logic [15:0] e_cnt);
    vec_t r;
    r.rx = rx; r.v = v; r.d = d; r.cw = cw; r.cb = cb; r.ca = ca; r.cd = cd;
    r.e_rst = e_rst; r.e_load = e_load; r.e_wr = e_wr; r.chk_bus = chk_bus;
    r.e_byt = e_byt; r.e_addr = e_addr; r.e_data = e_data; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step(input logic rx, input logic v, input logic [7:0] d);
    @(negedge clk);
    rx_prog     = rx;
    recv_data_v = v;
    recv_data   = d;
    cpu_wr      = 1'b0;
    cpu_byt     = 1'b0;
    cpu_addr    = 12'h000;
    cpu_wr_data = 16'h0000;
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    rx_prog = 1'b0; recv_data_v = 1'b0; recv_data = 8'h00;
    cpu_wr = 1'b0; cpu_byt = 1'b0; cpu_addr = 12'h000; cpu_wr_data = 16'h0000;

    //            rx v  d      cw cb ca      cd        rst ld wr chk byt addr    data      cnt
    vecs[0]  = mk(0, 0, 8'h00, 0, 0, 12'h000, 16'h0000, 1, 1, 0, 0, 0, 12'h000, 16'h0000, 16'd0);
    vecs[1]  = mk(0, 0, 8'h00, 0, 0, 12'h000, 16'h0000, 1, 1, 0, 0, 0, 12'h000, 16'h0000, 16'd0);
    vecs[2]  = mk(0, 0, 8'h00, 0, 0, 12'h000, 16'h0000, 1, 1, 0, 0, 0, 12'h000, 16'h0000, 16'd0);
    vecs[3]  = mk(0, 0, 8'h00, 1, 1, 12'h010, 16'hBEEF, 0, 0, 1, 1, 1, 12'h010, 16'hBEEF, 16'd0);
    vecs[4]  = mk(1, 0, 8'h00, 0, 0, 12'h022, 16'h1111, 0, 0, 0, 1, 0, 12'h022, 16'h1111, 16'd0);
    vecs[5]  = mk(1, 1, 8'h34, 1, 0, 12'h006, 16'hFFFF, 1, 1, 0, 0, 0, 12'h000, 16'h0000, 16'd0);
    vecs[6]  = mk(1, 1, 8'h12, 1, 0, 12'h006, 16'hFFFF, 1, 1, 0, 0, 0, 12'h000, 16'h0000, 16'd0);
    vecs[7]  = mk(1, 1, 8'h78, 1, 0, 12'h006, 16'hFFFF, 1, 1, 1, 1, 0, 12'h300, 16'h1234, 16'd1);
    vecs[8]  = mk(0, 1, 8'h56, 1, 0, 12'h006, 16'hFFFF, 1, 1, 0, 0, 0, 12'h000, 16'h0000, 16'd1);
    vecs[9]  = mk(0, 0, 8'h00, 1, 0, 12'h006, 16'hFFFF, 1, 1, 1, 1, 0, 12'h302, 16'h5678, 16'd2);
    vecs[10] = mk(0, 0, 8'h00, 0, 0, 12'h000, 16'h0000, 1, 1, 0, 0, 0, 12'h000, 16'h0000, 16'd2);
    vecs[11] = mk(0, 0, 8'h00, 0, 0, 12'h000, 16'h0000, 1, 1, 0, 0, 0, 12'h000, 16'h0000, 16'd2);
    vecs[12] = mk(0, 0, 8'h00, 0, 0, 12'h000, 16'h0000, 1, 1, 0, 0, 0, 12'h000, 16'h0000, 16'd2);
    vecs[13] = mk(0, 0, 8'h00, 0, 0, 12'h000, 16'h0000, 1, 1, 0, 0, 0, 12'h000, 16'h0000, 16'd2);
    vecs[14] = mk(0, 0, 8'h00, 1, 0, 12'h044, 16'hCAFE, 0, 0, 1, 1, 0, 12'h044, 16'hCAFE, 16'd2);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_loading", 32'(loading), 32'd1);
    chk("rst_load_cnt", 32'(load_cnt), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_csum", 32'(csum), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);

    // Reset release then first download (34 12 78 56), rx_prog falling with
    // the last byte, CPU writes ignored while loading.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      rx_prog     = vecs[i].rx;
      recv_data_v = vecs[i].v;
      recv_data   = vecs[i].d;
      cpu_wr      = vecs[i].cw;
      cpu_byt     = vecs[i].cb;
      cpu_addr    = vecs[i].ca;
      cpu_wr_data = vecs[i].cd;
      #1;
      chk($sformatf("v%0d_cpu_rst", i), 32'(cpu_rst), 32'(vecs[i].e_rst));
      chk($sformatf("v%0d_loading", i), 32'(loading), 32'(vecs[i].e_load));
      chk($sformatf("v%0d_mem_wr", i), 32'(mem_wr), 32'(vecs[i].e_wr));
      chk($sformatf("v%0d_load_cnt", i), 32'(load_cnt), 32'(vecs[i].e_cnt));
      if (vecs[i].chk_bus) begin
        chk($sformatf("v%0d_mem_byt", i), 32'(mem_byt), 32'(vecs[i].e_byt));
        chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
        chk($sformatf("v%0d_mem_data", i), 32'(mem_wr_data), 32'(vecs[i].e_data));
      end
    end
    chk("dl1_csum", 32'(csum), CSUM_ON ? 32'h14 : 32'h00);
    chk("dl1_ovf", 32'(ovf), 32'd0);

    // Odd-length download AA BB CC: word then trailing byte via FLUSH.
    step(1, 0, 8'h00);
    step(1, 1, 8'hAA);
    step(1, 1, 8'hBB);
    step(1, 1, 8'hCC);
    chk("dl2_w0_wr", 32'(mem_wr), 32'd1);
    chk("dl2_w0_byt", 32'(mem_byt), 32'd0);
    chk("dl2_w0_addr", 32'(mem_addr), 32'h300);
    chk("dl2_w0_data", 32'(mem_wr_data), 32'hBBAA);
    step(0, 0, 8'h00);
    chk("dl2_hi_wr", 32'(mem_wr), 32'd0);
    step(0, 0, 8'h00);
    chk("dl2_fl_wr", 32'(mem_wr), 32'd1);
    chk("dl2_fl_byt", 32'(mem_byt), 32'd1);
    chk("dl2_fl_addr", 32'(mem_addr), 32'h302);
    chk("dl2_fl_data", 32'(mem_wr_data), 32'h00CC);
    chk("dl2_load_cnt", 32'(load_cnt), 32'd2);
    chk("dl2_csum", 32'(csum), CSUM_ON ? 32'h31 : 32'h00);
    n = 0;
    while (cpu_rst && n <= 20) begin
      step(0, 0, 8'h00);
      n++;
    end
    chk("dl2_release_cycles", 32'(n), 32'd5);

    // Six bytes: the 11-bit instance runs off the end of memory.
    step(1, 0, 8'h00);
    step(1, 1, 8'h01);
    step(1, 1, 8'h02);
    step(1, 1, 8'h03);
    chk("dl3_w0_addr", 32'(mem_addr), 32'h300);
    chk("dl3_w0_data", 32'(mem_wr_data), 32'h0201);
    chk("sm_w0_wr", 32'(s_mem_wr), 32'd1);
    chk("sm_w0_addr", 32'(s_mem_addr), 32'h7FC);
    chk("sm_w0_data", 32'(s_mem_wr_data), 32'h0201);
    step(1, 1, 8'h04);
    step(1, 1, 8'h05);
    chk("sm_w1_wr", 32'(s_mem_wr), 32'd1);
    chk("sm_w1_addr", 32'(s_mem_addr), 32'h7FE);
    chk("sm_w1_data", 32'(s_mem_wr_data), 32'h0403);
    step(0, 1, 8'h06);
    chk("sm_ovf_before", 32'(s_ovf), 32'd0);
    step(0, 0, 8'h00);
    chk("dl3_w2_wr", 32'(mem_wr), 32'd1);
    chk("dl3_w2_addr", 32'(mem_addr), 32'h304);
    chk("dl3_w2_data", 32'(mem_wr_data), 32'h0605);
    chk("dl3_load_cnt", 32'(load_cnt), 32'd3);
    chk("dl3_ovf", 32'(ovf), 32'd0);
    chk("sm_w2_wr", 32'(s_mem_wr), 32'd0);
    chk("sm_ovf", 32'(s_ovf), 32'd1);
    chk("sm_load_cnt", 32'(s_load_cnt), 32'd2);
    chk("sm_csum", 32'(s_csum), CSUM_ON ? 32'h15 : 32'h00);

    // Asynchronous reset between clock edges.
    step(0, 0, 8'h00);
    rst = 1'b1;
    #1;
    chk("arst_load_cnt", 32'(load_cnt), 32'd0);
    chk("arst_sm_ovf", 32'(s_ovf), 32'd0);
    chk("arst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("arst_csum", 32'(csum), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Sequences program download into the word memory (lo/hi byte BRAM pair behind mem) from the UART receiver while rx_prog is high.
- Holds the CPU in reset during download and owns the memory write port for that time.
- Returns the memory port to the CPU and releases CPU reset after a fixed delay once download ends.
- Sits between cpu/uart and mem inside mcu.

Parameters:
ADDR_WIDTH, `ADDR_WIDTH, byte-address width of mem
LOAD_BASE, 'h300, byte address of first loaded word; must be even
RELEASE_CYC, 4, cycles cpu_rst stays high after download end or after reset, range 1..255

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rx_prog  in  1  download-mode request, level
recv_data  in  8  received UART byte
recv_data_v  in  1  one-cycle strobe, recv_data valid
cpu_addr  in  ADDR_WIDTH  CPU byte address
cpu_wr  in  1  CPU write strobe
cpu_byt  in  1  CPU byte access
cpu_wr_data  in  16  CPU write data
mem_addr  out  ADDR_WIDTH  to mem.addr
mem_wr  out  1  to mem.wr
mem_byt  out  1  to mem.byt
mem_wr_data  out  16  to mem.wr_data
cpu_rst  out  1  reset to CPU
loading  out  1  high when state is not RUN
load_cnt  out  16  words written in last/current download, including a trailing byte
ovf  out  1  sticky: data arrived past end of memory
csum  out  8  byte checksum (see Optional Feature)

Behaviour:
- States: REL, RUN, LO, HI, FLUSH. Asynchronous reset -> REL, rel_cnt=0, cpu_rst=1, loading=1, load_cnt=0, ovf=0, csum=0, loader write regs 0.
- REL: cpu_rst=1. rel_cnt counts up each cycle. At rel_cnt==RELEASE_CYC-1 -> RUN, rel_cnt cleared. If rx_prog=1 while in REL -> LO. After reset, cpu_rst is first low in cycle RELEASE_CYC.
- RUN: cpu_rst=0. mem_* = cpu_* combinationally (zero added latency). rx_prog=1 -> LO. Same edge sets ptr=LOAD_BASE, load_cnt=0, ovf=0, csum=0, cpu_rst=1.
- LO: on recv_data_v, lo_buf<=recv_data -> HI. Else if rx_prog=0 -> REL.
- HI: on recv_data_v -> LO, and next cycle issue one write:
  - mem_wr=1, mem_byt=0, mem_addr=ptr, mem_wr_data={recv_data,lo_buf}.
  - ptr+=2, load_cnt+=1.
  - Else if rx_prog=0 -> FLUSH.
- FLUSH: single cycle. Writes mem_byt=1, mem_addr=ptr, mem_wr_data={8'h00,lo_buf}; load_cnt+=1 -> REL.
- Priority: recv_data_v is accepted in the same cycle rx_prog falls. The fall is acted on the following cycle.
- In every state except RUN:
  - mem_addr/mem_byt/mem_wr_data come from registered loader values.
  - mem_wr is high only for loader write cycles.
  - cpu_wr is ignored (dropped, never queued).
- Overflow: if a write would target ptr > 2^ADDR_WIDTH-2 (word) or ptr > 2^ADDR_WIDTH-1 (byte):
  - The write is suppressed, ovf=1, and load_cnt is not incremented.
  - ptr does not wrap; later bytes are also dropped.
- load_cnt saturates at 16'hFFFF.
- rx_prog rising while in LO/HI has no effect; re-entry to LO from REL does not clear load_cnt/ovf/csum, so the counts continue.
- Reset mid-download: immediate return to REL. A write pending in the loader register is lost.

Optional Feature:
- Macro PROG_LOADER_CSUM_EN.
- Defined: csum = 8-bit wrapping sum of every byte accepted via recv_data_v since the last RUN->LO transition, including dropped overflow bytes. Updated the cycle after the strobe.
- Undefined: csum tied to 8'h00, no adder or register.

Test Plan:
- Reset release, rx_prog=0, RELEASE_CYC=4 -> cpu_rst high exactly 4 cycles after rst falls, then 0; loading falls with it; mem_* follow cpu_* the same cycle.
- rx_prog=1, bytes 34,12,78,56, rx_prog=0:
  - Write 1234 at 300, then 5678 at 302, both byt=0.
  - load_cnt=2; cpu_rst released 4 cycles later.
  - csum=0x14 with macro, 0 without.
- rx_prog=1, bytes AA,BB,CC, rx_prog=0 -> word BBAA at 300, byte write 00CC byt=1 at 302, load_cnt=2.
- During download, cpu_wr=1 cpu_addr=006 -> no mem_wr unless a loader write coincides, and then with the loader address/data.
- ADDR_WIDTH=11, LOAD_BASE=7FC, 6 bytes -> writes at 7FC and 7FE, third word suppressed, ovf=1, load_cnt=2.
- rx_prog falls on the same cycle as the 2nd byte strobe -> full word written, no FLUSH byte write.
